speicher_zugriff: RTL

//  Initiator side of the single-port RAM strobe/acknowledge interface: the processor's load/store unit.

---
 rtl/speicher_zugriff_pkg.sv | 18 +
 rtl/speicher_zugriff_if.sv | 33 +++
 rtl/speicher_zugriff.sv | 128 ++++++++++++
 3 files changed

// File: rtl/speicher_zugriff_pkg.sv
// Shared load/store-unit definitions: access state encoding and default word width.
package speicher_zugriff_pkg;

  localparam int WORDSIZE_DEFAULT = 32;

  localparam logic [1:0] ZS_LEER      = 2'd0;
  localparam logic [1:0] ZS_ANFORDERN = 2'd1;
  localparam logic [1:0] ZS_WARTEN    = 2'd2;
  localparam logic [1:0] ZS_ABKLINGEN = 2'd3;

  typedef enum logic [1:0] {
    LEER      = ZS_LEER,
    ANFORDERN = ZS_ANFORDERN,
    WARTEN    = ZS_WARTEN,
    ABKLINGEN = ZS_ABKLINGEN
  } zustand_t;

endpackage

// File: rtl/speicher_zugriff_if.sv
// Core-side request bus and RAM strobe/acknowledge bus of the load/store unit.
// Core: a request is taken at the edge where Anfrage && Bereit; Anfrage is ignored while Bereit=0.
// RAM: LesenAn/SchreibenAn are one-cycle strobes; DatenBereit/DatenGeschrieben acknowledge them.
interface speicher_zugriff_if #(
  parameter int WORDSIZE = 32,
  parameter int ADRBITS  = 5
);
  logic                Anfrage;
  logic                Schreiben;
  logic [WORDSIZE-1:0] CpuAdresse;
  logic [WORDSIZE-1:0] CpuDaten;
  logic                Bereit;
  logic                Fertig;
  logic                Fehler;
  logic [WORDSIZE-1:0] GeleseneDaten;
  logic                LesenAn;
  logic                SchreibenAn;
  logic [WORDSIZE-1:0] DatenRein;
  logic [ADRBITS-1:0]  Adresse;
  logic [WORDSIZE-1:0] DatenRaus;
  logic                DatenBereit;
  logic                DatenGeschrieben;

  modport master (
    input  Anfrage, Schreiben, CpuAdresse, CpuDaten, DatenRaus, DatenBereit, DatenGeschrieben,
    output Bereit, Fertig, Fehler, GeleseneDaten, LesenAn, SchreibenAn, DatenRein, Adresse
  );

  modport slave (
    output Anfrage, Schreiben, CpuAdresse, CpuDaten, DatenRaus, DatenBereit, DatenGeschrieben,
    input  Bereit, Fertig, Fehler, GeleseneDaten, LesenAn, SchreibenAn, DatenRein, Adresse
  );
endinterface

// File: rtl/speicher_zugriff.sv
// Load/store unit: checks a core word request, strobes the RAM once, waits for its ack with a
// watchdog, and reports completion (Fertig) or failure (Fehler) as registered one-cycle pulses.
module speicher_zugriff
  import speicher_zugriff_pkg::*;
#(
  parameter int WORDSIZE = WORDSIZE_DEFAULT,
  parameter int WORDS    = 32,
  parameter int TIMEOUT  = 15
) (
  input  logic               Clock,
  input  logic               Reset,
  speicher_zugriff_if.master bus,
  output zustand_t           o_zustand
);

  localparam int ADRBITS = $clog2(WORDS);
  localparam int TW      = $clog2(TIMEOUT + 1);

  zustand_t            r_zustand, w_zustand_next;
  logic [TW-1:0]       r_timer, w_timer_next;
  logic                r_schreiben, w_schreiben_next;
  logic                r_bereit, w_bereit_next;
  logic                r_fertig, w_fertig_next;
  logic                r_fehler, w_fehler_next;
  logic                r_lesen_an, w_lesen_an_next;
  logic                r_schreiben_an, w_schreiben_an_next;
  logic [WORDSIZE-1:0] r_gelesen, w_gelesen_next;
  logic [WORDSIZE-1:0] r_daten_rein, w_daten_rein_next;
  logic [ADRBITS-1:0]  r_adresse, w_adresse_next;
  logic                w_adr_fehler;
  logic                w_ack;

  assign w_adr_fehler = (bus.CpuAdresse[1:0] != 2'b00) ||
                        ({2'b00, bus.CpuAdresse[WORDSIZE-1:2]} >= WORDSIZE'(WORDS));

  // Only the ack matching the direction of the access in flight counts.
  assign w_ack = r_schreiben ? bus.DatenGeschrieben : bus.DatenBereit;

  always_comb begin
    w_zustand_next      = r_zustand;
    w_timer_next        = r_timer;
    w_schreiben_next    = r_schreiben;
    w_fertig_next       = 1'b0;
    w_fehler_next       = 1'b0;
    w_lesen_an_next     = 1'b0;
    w_schreiben_an_next = 1'b0;
    w_gelesen_next      = r_gelesen;
    w_daten_rein_next   = r_daten_rein;
    w_adresse_next      = r_adresse;
    case (r_zustand)
      LEER: begin
        if (bus.Anfrage) begin
          if (w_adr_fehler) begin
            w_fehler_next = 1'b1;
          end else begin
            w_adresse_next      = bus.CpuAdresse[ADRBITS+1:2];
            w_daten_rein_next   = bus.CpuDaten;
            w_schreiben_next    = bus.Schreiben;
            w_schreiben_an_next = bus.Schreiben;
            w_lesen_an_next     = !bus.Schreiben;
            w_zustand_next      = ANFORDERN;
          end
        end
      end
      ANFORDERN: begin
        w_timer_next   = '0;
        w_zustand_next = WARTEN;
      end
      WARTEN: begin
        if (w_ack) begin
          w_fertig_next  = 1'b1;
          if (!r_schreiben) w_gelesen_next = bus.DatenRaus;
          w_zustand_next = ABKLINGEN;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_fehler_next  = 1'b1;
          w_zustand_next = ABKLINGEN;
        end else if (r_timer != TW'(TIMEOUT)) begin
          w_timer_next = r_timer + 1'b1;
        end
      end
      ABKLINGEN: begin
        // A RAM still holding its ack must not complete the next request.
        if (!w_ack) w_zustand_next = LEER;
      end
      default: w_zustand_next = LEER;
    endcase
    w_bereit_next = (w_zustand_next == LEER);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_zustand      <= LEER;
      r_timer        <= '0;
      r_schreiben    <= 1'b0;
      r_bereit       <= 1'b1;
      r_fertig       <= 1'b0;
      r_fehler       <= 1'b0;
      r_lesen_an     <= 1'b0;
      r_schreiben_an <= 1'b0;
      r_gelesen      <= '0;
      r_daten_rein   <= '0;
      r_adresse      <= '0;
    end else begin
      r_zustand      <= w_zustand_next;
      r_timer        <= w_timer_next;
      r_schreiben    <= w_schreiben_next;
      r_bereit       <= w_bereit_next;
      r_fertig       <= w_fertig_next;
      r_fehler       <= w_fehler_next;
      r_lesen_an     <= w_lesen_an_next;
      r_schreiben_an <= w_schreiben_an_next;
      r_gelesen      <= w_gelesen_next;
      r_daten_rein   <= w_daten_rein_next;
      r_adresse      <= w_adresse_next;
    end
  end

  assign bus.Bereit        = r_bereit;
  assign bus.Fertig        = r_fertig;
  assign bus.Fehler        = r_fehler;
  assign bus.GeleseneDaten = r_gelesen;
  assign bus.LesenAn       = r_lesen_an;
  assign bus.SchreibenAn   = r_schreiben_an;
  assign bus.DatenRein     = r_daten_rein;
  assign bus.Adresse       = r_adresse;
  assign o_zustand         = r_zustand;

endmodule
